// File: rtl/emif_avmm_responder.sv
// emif_avmm_responder: single-beat Avalon-MM memory responder with calibration window,
// fixed-latency read pipeline and a write-response queue that yields to read beats.
module emif_avmm_responder #(
  parameter int MEM_AW        = 8,
  parameter int RD_LAT        = 4,
  parameter int MAX_RD        = 4,
  parameter int WR_FIFO_DEPTH = 4,
  parameter int INIT_CYCLES   = 16
) (
  input  logic         Clk_400,
  input  logic         SoftReset,
  input  logic [25:0]  avs_address,
  input  logic         avs_write,
  input  logic         avs_read,
  input  logic [511:0] avs_writedata,
  input  logic [63:0]  avs_byteenable,
  input  logic [11:0]  avs_burstcount,
  output logic         avs_waitrequest,
  output logic [63:0]  avs_readdata,
  output logic         avs_readdatavalid,
  output logic         avs_writeresponsevalid,
  output logic [1:0]   avs_response,
  output logic         calib_done,
  output logic         protocol_err
);
  localparam int RW = $clog2(MAX_RD + 1);
  localparam int QW = $clog2(WR_FIFO_DEPTH + 1);
  localparam int PW = WR_FIFO_DEPTH > 1 ? $clog2(WR_FIFO_DEPTH) : 1;
  localparam int IW = $clog2(INIT_CYCLES + 1);
  logic [63:0]       mem [2**MEM_AW];
  logic [RD_LAT-1:0] pv;
  logic [63:0]       pd [RD_LAT];
  logic [1:0]        pr [RD_LAT];
  logic [1:0]        wq [WR_FIFO_DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [QW-1:0]     wq_cnt;
  logic [RW-1:0]     rd_cnt;
  logic [IW-1:0]     init_cnt;
  logic [MEM_AW-1:0] idx;
  logic [1:0]        resp;
  logic              oor, rd_acc, wr_acc, rdv, wr_pop, unused;
  assign unused = ^{avs_writedata[511:64], avs_byteenable[63:8]};
  assign idx = avs_address[MEM_AW-1:0];
  assign oor = (avs_address >> MEM_AW) != 26'd0;
  assign resp = oor ? 2'b11 : avs_burstcount != 12'd1 ? 2'b10 : 2'b00;
  assign avs_waitrequest = !calib_done | rd_cnt == RW'(MAX_RD) | wq_cnt == QW'(WR_FIFO_DEPTH);
  // a simultaneous read+write keeps the write and drops the read
  assign rd_acc = avs_read & !avs_write & !avs_waitrequest;
  assign wr_acc = avs_write & !avs_waitrequest;
  assign rdv = pv[RD_LAT-1];
  assign wr_pop = (wq_cnt != '0) & !rdv;
  assign avs_readdatavalid = rdv;
  assign avs_readdata = pd[RD_LAT-1];
  assign avs_writeresponsevalid = wr_pop;
  assign avs_response = rdv ? pr[RD_LAT-1] : wr_pop ? wq[rp] : 2'b00;
  always_ff @(posedge Clk_400)
    if (wr_acc && resp == 2'b00)
      for (int i = 0; i < 8; i++)
        if (avs_byteenable[i]) mem[idx][8*i +: 8] <= avs_writedata[8*i +: 8];
  always_ff @(posedge Clk_400)
    if (wr_acc) wq[wp] <= resp;
  always_ff @(posedge Clk_400 or posedge SoftReset)
    if (SoftReset) begin
      pv <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pd[i] <= '0;
        pr[i] <= '0;
      end
      wp <= '0;
      rp <= '0;
      wq_cnt <= '0;
      rd_cnt <= '0;
      init_cnt <= '0;
      calib_done <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (!calib_done) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == IW'(INIT_CYCLES - 1)) calib_done <= 1'b1;
      end
      if (avs_read & avs_write & !avs_waitrequest) protocol_err <= 1'b1;
      pv <= {pv[RD_LAT-2:0], rd_acc};
      pd[0] <= rd_acc && resp == 2'b00 ? mem[idx] : 64'd0;
      pr[0] <= rd_acc ? resp : 2'b00;
      for (int i = 1; i < RD_LAT; i++) begin
        pd[i] <= pd[i-1];
        pr[i] <= pr[i-1];
      end
      rd_cnt <= rd_cnt + RW'(rd_acc) - RW'(rdv);
      wq_cnt <= wq_cnt + QW'(wr_acc) - QW'(wr_pop);
      if (wr_acc) wp <= wp == PW'(WR_FIFO_DEPTH - 1) ? '0 : wp + 1'b1;
      if (wr_pop) rp <= rp == PW'(WR_FIFO_DEPTH - 1) ? '0 : rp + 1'b1;
    end
endmodule

// File: tb/tb_emif_avmm_responder.sv
// tb_emif_avmm_responder: directed checks of calibration, byte-enabled writes, read latency,
// error responses, outstanding-read limit, response arbitration and reset behaviour.
module tb_emif_avmm_responder;
  logic         Clk_400 = 1'b0, SoftReset = 1'b1, avs_write = 1'b0, avs_read = 1'b0;
  logic [25:0]  avs_address = '0;
  logic [511:0] avs_writedata = '0;
  logic [63:0]  avs_byteenable = '0;
  logic [11:0]  avs_burstcount = 12'd1;
  logic         avs_waitrequest, avs_readdatavalid, avs_writeresponsevalid, calib_done, protocol_err;
  logic [63:0]  avs_readdata;
  logic [1:0]   avs_response;
  int checks = 0, errors = 0;
  emif_avmm_responder dut (
    .Clk_400(Clk_400), .SoftReset(SoftReset), .avs_address(avs_address), .avs_write(avs_write),
    .avs_read(avs_read), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_burstcount(avs_burstcount), .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .avs_writeresponsevalid(avs_writeresponsevalid),
    .avs_response(avs_response), .calib_done(calib_done), .protocol_err(protocol_err)
  );
  always #5 Clk_400 = ~Clk_400;
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_write(input logic [25:0] a, input logic [63:0] d, input logic [7:0] be,
                          input logic [11:0] bc, input logic [1:0] er, input string tag);
    avs_address = a;
    avs_writedata = {448'd0, d};
    avs_byteenable = {56'd0, be};
    avs_burstcount = bc;
    avs_write = 1'b1;
    chk({tag, "_wait"}, avs_waitrequest, 0);
    @(negedge Clk_400);
    avs_write = 1'b0;
    avs_burstcount = 12'd1;
    chk({tag, "_wrv"}, avs_writeresponsevalid, 1);
    chk({tag, "_resp"}, avs_response, er);
  endtask
  task automatic do_read(input logic [25:0] a, input logic [63:0] ed, input logic [1:0] er, input string tag);
    avs_address = a;
    avs_read = 1'b1;
    chk({tag, "_wait"}, avs_waitrequest, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge Clk_400);
      avs_read = 1'b0;
      chk({tag, "_rdv"}, avs_readdatavalid, i == 4);
      chk({tag, "_data"}, avs_readdata, i == 4 ? ed : 64'd0);
      if (i == 4) chk({tag, "_resp"}, avs_response, er);
    end
  endtask
  initial begin
    logic [11:0] exp_v;
    logic [6:0]  exp_w;
    int k, b;
    repeat (3) @(negedge Clk_400);
    chk("rst_wait", avs_waitrequest, 1);
    chk("rst_calib", calib_done, 0);
    chk("rst_rdv", avs_readdatavalid, 0);
    chk("rst_wrv", avs_writeresponsevalid, 0);
    chk("rst_perr", protocol_err, 0);
    SoftReset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge Clk_400);
      chk("init_wait", avs_waitrequest, i < 16);
      chk("init_calib", calib_done, i >= 16);
    end
    do_write(26'd5, 64'hDEADBEEF_CAFEF00D, 8'hFF, 12'd1, 2'b00, "wr5");
    do_read(26'd5, 64'hDEADBEEF_CAFEF00D, 2'b00, "rd5");
    do_write(26'd5, 64'h11223344_55667788, 8'h0F, 12'd1, 2'b00, "wr5_be");
    do_read(26'd5, 64'hDEADBEEF_55667788, 2'b00, "rd5_be");
    do_read(26'd300, 64'd0, 2'b11, "rd300");
    do_write(26'd300, 64'h1, 8'hFF, 12'd1, 2'b11, "wr300");
    do_write(26'd5, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 12'd4, 2'b10, "wr_burst4");
    do_read(26'd5, 64'hDEADBEEF_55667788, 2'b00, "rd5_unchanged");
    chk("idle_resp", avs_response, 0);
    for (int j = 0; j < 6; j++) do_write(26'(10 + j), {32'hA5A50000, 32'(10 + j)}, 8'hFF, 12'd1, 2'b00, "fill");
    exp_v = 12'b0110_1111_0000;
    exp_w = 7'b001_0000;
    k = 0;
    b = 0;
    for (int c = 0; c < 12; c++) begin
      chk("b2b_rdv", avs_readdatavalid, exp_v[c]);
      if (avs_readdatavalid) begin
        chk("b2b_data", avs_readdata, {32'hA5A50000, 32'(10 + b)});
        b++;
      end
      if (k < 6) begin
        chk("b2b_wait", avs_waitrequest, exp_w[c]);
        avs_read = 1'b1;
        avs_address = 26'(10 + k);
        if (!avs_waitrequest) k++;
      end else avs_read = 1'b0;
      @(negedge Clk_400);
    end
    chk("b2b_beats", b, 6);
    chk("b2b_wait_end", avs_waitrequest, 0);
    avs_address = 26'd300;
    avs_read = 1'b1;
    @(negedge Clk_400);
    avs_read = 1'b0;
    repeat (2) @(negedge Clk_400);
    avs_address = 26'd20;
    avs_writedata = 512'h55;
    avs_byteenable = 64'hFF;
    avs_burstcount = 12'd2;
    avs_write = 1'b1;
    @(negedge Clk_400);
    avs_write = 1'b0;
    avs_burstcount = 12'd1;
    chk("col_rdv", avs_readdatavalid, 1);
    chk("col_rd_resp", avs_response, 2'b11);
    chk("col_rd_data", avs_readdata, 0);
    chk("col_wrv_blocked", avs_writeresponsevalid, 0);
    @(negedge Clk_400);
    chk("col_wrv", avs_writeresponsevalid, 1);
    chk("col_wr_resp", avs_response, 2'b10);
    chk("col_rdv_off", avs_readdatavalid, 0);
    @(negedge Clk_400);
    chk("col_wrv_done", avs_writeresponsevalid, 0);
    chk("col_resp_idle", avs_response, 0);
    avs_address = 26'd7;
    avs_writedata = 512'h77;
    avs_byteenable = 64'hFF;
    avs_write = 1'b1;
    avs_read = 1'b1;
    chk("rw_wait", avs_waitrequest, 0);
    @(negedge Clk_400);
    avs_write = 1'b0;
    avs_read = 1'b0;
    chk("rw_perr", protocol_err, 1);
    chk("rw_wrv", avs_writeresponsevalid, 1);
    chk("rw_resp", avs_response, 0);
    repeat (4) begin
      @(negedge Clk_400);
      chk("rw_read_dropped", avs_readdatavalid, 0);
    end
    do_read(26'd7, 64'h77, 2'b00, "rd7");
    chk("perr_sticky", protocol_err, 1);
    avs_address = 26'd5;
    avs_read = 1'b1;
    repeat (2) @(negedge Clk_400);
    avs_read = 1'b0;
    @(negedge Clk_400);
    avs_address = 26'd22;
    avs_writedata = 512'h22;
    avs_write = 1'b1;
    @(negedge Clk_400);
    avs_write = 1'b0;
    chk("mid_rdv", avs_readdatavalid, 1);
    chk("mid_wrv", avs_writeresponsevalid, 0);
    SoftReset = 1'b1;
    #1;
    chk("mid_rst_rdv", avs_readdatavalid, 0);
    chk("mid_rst_wrv", avs_writeresponsevalid, 0);
    chk("mid_rst_data", avs_readdata, 0);
    chk("mid_rst_wait", avs_waitrequest, 1);
    chk("mid_rst_calib", calib_done, 0);
    chk("mid_rst_perr", protocol_err, 0);
    repeat (2) @(negedge Clk_400);
    SoftReset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge Clk_400);
      chk("post_rst_rdv", avs_readdatavalid, 0);
      chk("post_rst_wrv", avs_writeresponsevalid, 0);
    end
    chk("post_rst_wait", avs_waitrequest, 0);
    do_read(26'd5, 64'hDEADBEEF_55667788, 2'b00, "mem_kept");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/emif_avmm_responder.md
EMIF_AVMM_RESPONDER -- requirements
Module: emif_avmm_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 8, meaning log2 of the number of 64-bit words stored.
REQ-002 SHALL have parameter RD_LAT, default 4, meaning cycles from read acceptance to avs_readdatavalid (legal range 2..16).
REQ-003 SHALL have parameter MAX_RD, default 4, meaning the maximum number of outstanding reads.
REQ-004 SHALL have parameter WR_FIFO_DEPTH, default 4, meaning the number of write-response queue entries.
REQ-005 SHALL have parameter INIT_CYCLES, default 16, meaning calibration cycles after reset release.
REQ-006 SHALL have port Clk_400, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port SoftReset, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port avs_address, input, 26 bits: word address.
REQ-009 SHALL have port avs_write, input, 1 bit: write request.
REQ-010 SHALL have port avs_read, input, 1 bit: read request.
REQ-011 SHALL have port avs_writedata, input, 512 bits: only [63:0] is stored.
REQ-012 SHALL have port avs_byteenable, input, 64 bits: only [7:0] is used, as per-byte enables for [63:0].
REQ-013 SHALL have port avs_burstcount, input, 12 bits: burst length; only 1 is supported.
REQ-014 SHALL have port avs_waitrequest, output, 1 bit: command stall.
REQ-015 SHALL have port avs_readdata, output, 64 bits: read data.
REQ-016 SHALL have port avs_readdatavalid, output, 1 bit: read data valid.
REQ-017 SHALL have port avs_writeresponsevalid, output, 1 bit: write response valid.
REQ-018 SHALL have port avs_response, output, 2 bits: 00 OKAY, 10 SLVERR, 11 DECODEERROR.
REQ-019 SHALL have port calib_done, output, 1 bit: high once the init window has expired.
REQ-020 SHALL have port protocol_err, output, 1 bit: sticky flag for simultaneous read and write.

Function
REQ-021 Acceptance SHALL occur in any cycle where (avs_read|avs_write) & !avs_waitrequest.
REQ-022 avs_waitrequest SHALL be combinational from registered state: !calib_done | (rd_cnt==MAX_RD) | (wq_cnt==WR_FIFO_DEPTH).
REQ-023 rd_cnt SHALL count reads accepted but not yet delivered; acceptance and delivery in the same cycle leave it unchanged.
REQ-024 An init counter SHALL start at reset release and count INIT_CYCLES cycles; calib_done SHALL then rise and stay high until the next reset.
REQ-025 An accepted write with in-range address (address < 2**MEM_AW), burstcount==1 SHALL update the enabled bytes of mem[address] at the acceptance edge.
REQ-026 An accepted read SHALL sample mem[address] at the acceptance edge; a write accepted in cycle N SHALL be visible to a read accepted in cycle N+1.
REQ-027 Read data SHALL travel a RD_LAT-stage shift pipeline carrying {valid, data, resp}; avs_readdatavalid SHALL assert exactly RD_LAT cycles after acceptance, one beat per read, in order.
REQ-028 Back-to-back reads SHALL be accepted every cycle while rd_cnt<MAX_RD, yielding back-to-back readdatavalid beats.
REQ-029 Response codes SHALL be: address >= 2**MEM_AW -> 11, with read data 0 and no write; else burstcount!=1 -> 10, with read data 0 and no write; else 00.
REQ-030 Each accepted write SHALL push its response code into the write-response FIFO.
REQ-031 The FIFO head SHALL be popped onto avs_writeresponsevalid/avs_response only in cycles where the read pipeline is not delivering; reads SHALL always win the shared avs_response bus.
REQ-032 The FIFO SHALL support simultaneous push and pop with wq_cnt unchanged; it cannot overflow because waitrequest blocks writes at full.
REQ-033 If read and write are asserted together while not stalled: the write SHALL be accepted, the read dropped, and protocol_err set until reset.
REQ-034 avs_readdatavalid and avs_writeresponsevalid SHALL never be high in the same cycle.
REQ-035 avs_readdata and avs_response SHALL be 0 in cycles with no valid.

Reset
REQ-036 SoftReset SHALL asynchronously clear all pipelines, counters, FIFO pointers, calib_done, and protocol_err, and drive every valid output to 0.
REQ-037 During reset avs_waitrequest SHALL be 1.
REQ-038 In-flight reads and write responses SHALL be discarded on reset and never delivered.
REQ-039 Memory contents SHALL NOT be reset.

Verification
REQ-040 Reset release: waitrequest=1 for 16 cycles, then 0; calib_done rises at cycle 16.
REQ-041 Write 0xDEADBEEF_CAFEF00D to address 5 with byteenable 0xFF, then read address 5: writeresponsevalid with response 00; readdatavalid exactly 4 cycles after read acceptance with data 0xDEADBEEF_CAFEF00D.
REQ-042 Write with byteenable 0x0F of 0x11223344_55667788 over 0xDEADBEEF_CAFEF00D at address 5, then read: data 0xDEADBEEF_55667788.
REQ-043 Read address 300 -> data 0 with response 11; write with burstcount 4 -> response 10, memory unchanged.
REQ-044 Six reads issued back-to-back: waitrequest asserts after the 4th acceptance and the remaining two are accepted as beats retire; six in-order beats are delivered.
REQ-045 A read and a write whose responses collide in one cycle: the read beat goes first and the write response follows the next free cycle; read+write asserted together sets protocol_err=1; reset mid-burst clears all valids within the same cycle.
